// File: rtl/sd_scan_ctrl.sv
// Word-level scheduler around an overlapping serial pattern detector: words in, per-word match
// counts out, with history carried across word boundaries until a stream's last word.
module sd_scan_ctrl #(
  parameter int unsigned           WORD_W   = 8,
  parameter int unsigned           PAT_W    = 4,
  parameter logic [PAT_W-1:0]      PAT_INIT = 4'b1010,
  parameter int unsigned           CNT_W    = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [15:0]       total_hits
);

  localparam int unsigned FW = $clog2(PAT_W + 1);
  localparam int unsigned IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [FW-1:0] FillMax = FW'(PAT_W);
  localparam logic [IW-1:0] IdxLast = IW'(WORD_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StReport} state_e;

  state_e            state_q;
  logic [WORD_W-1:0] shreg_q;
  logic              last_q;
  logic [IW-1:0]     idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  hist_q;
  logic [FW-1:0]     fill_q;
  logic [15:0]       total_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [PAT_W-1:0]  hist_d;
  logic [FW-1:0]     fill_d;
  logic              hit;

  // Next history/fill for the bit being shifted this cycle; a match needs a full window.
  always_comb begin
    hist_d = {hist_q[PAT_W-2:0], shreg_q[WORD_W-1]};
    fill_d = (fill_q == FillMax) ? fill_q : fill_q + FW'(1);
    hit    = (hist_d == pat_q) && (fill_d == FillMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      pat_q       <= PAT_INIT;
      hist_q      <= '0;
      fill_q      <= '0;
      total_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            shreg_q    <= in_data;
            last_q     <= in_last;
            idx_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StShift;
          end else if (cfg_load) begin
            pat_q  <= cfg_pattern;
            hist_q <= '0;
            fill_q <= '0;
          end
        end
        StShift: begin
          shreg_q <= shreg_q << 1;
          hist_q  <= hist_d;
          fill_q  <= fill_d;
          if (hit) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (total_q != 16'hFFFF) total_q <= total_q + 16'd1;
          end
          if (idx_q == IdxLast) begin
            out_valid_q <= 1'b1;
            state_q     <= StReport;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        StReport: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
            if (last_q) begin
              hist_q <= '0;
              fill_q <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_count  = cnt_q;
  assign total_hits = total_q;

endmodule

// File: tb/tb_sd_scan_ctrl.sv
// Self-checking bench for sd_scan_ctrl: vector table plus hand-written multi-cycle sequences,
// with per-word counts checked through a scoreboard queue.
module tb_sd_scan_ctrl;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = $clog2(WORD_W + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_load;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [15:0]       total_hits;

  sd_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .total_hits (total_hits)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_q[$];

  typedef struct {
    logic [WORD_W-1:0] data;
    logic              last;
    logic [CNT_W-1:0]  exp_cnt;
    logic [15:0]       exp_tot;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each result at its handshake, sampled mid-low-phase.
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got count %0d expected no result", out_count);
      end else begin
        logic [CNT_W-1:0] e;
        e = exp_q.pop_front();
        if (out_count !== e) begin
          failures++;
          $display("FAIL out_count: got %0d expected %0d", out_count, e);
        end
      end
    end
  end

  task automatic send_word(input logic [WORD_W-1:0] d, input logic l,
                           input logic [CNT_W-1:0] e);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hAA, 1'b1, 4'd3, 16'd3};
    vecs[1] = '{8'h05, 1'b0, 4'd0, 16'd3};
    vecs[2] = '{8'h00, 1'b1, 4'd1, 16'd4};
    vecs[3] = '{8'h05, 1'b1, 4'd0, 16'd4};
    vecs[4] = '{8'h00, 1'b1, 4'd0, 16'd4};
    vecs[5] = '{8'h0A, 1'b1, 4'd1, 16'd5};

    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_total", 32'(total_hits), 32'd0);

    foreach (vecs[i]) begin
      send_word(vecs[i].data, vecs[i].last, vecs[i].exp_cnt);
      wait_done();
      check("vec_total", 32'(total_hits), 32'(vecs[i].exp_tot));
      check("vec_in_ready", 32'(in_ready), 32'd1);
    end

    // Load 1111 in IDLE, then FF -> 5 overlapping matches.
    cfg_load = 1'b1; cfg_pattern = 4'b1111;
    @(negedge clk);
    cfg_load = 1'b0;
    send_word(8'hFF, 1'b1, 4'd5);
    wait_done();
    check("cfg_total", 32'(total_hits), 32'd10);

    // Back to 1010; a cfg_load coinciding with an accepted word is ignored.
    cfg_load = 1'b1; cfg_pattern = 4'b1010;
    @(negedge clk);
    cfg_pattern = 4'b1111;
    send_word(8'hFF, 1'b1, 4'd0);
    cfg_load = 1'b0;
    wait_done();
    send_word(8'hFF, 1'b1, 4'd0);
    wait_done();

    // cfg_load during SHIFT is ignored.
    send_word(8'hAA, 1'b1, 4'd3);
    cfg_load = 1'b1; cfg_pattern = 4'b1111;
    repeat (3) @(negedge clk);
    cfg_load = 1'b0;
    wait_done();
    send_word(8'hFF, 1'b1, 4'd0);
    wait_done();
    check("shift_cfg_total", 32'(total_hits), 32'd13);

    // Latency and back-pressure.
    out_ready = 1'b0;
    send_word(8'hAA, 1'b1, 4'd3);
    repeat (7) @(negedge clk);
    check("latency_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_count", 32'(out_count), 32'd3);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    repeat (12) @(negedge clk);
    check("bp_no_consume", 32'(out_valid), 32'd0);
    check("bp_total", 32'(total_hits), 32'd16);

    // Reset mid-SHIFT discards the word and clears history, pattern and totals.
    cfg_load = 1'b1; cfg_pattern = 4'b0110;
    @(negedge clk);
    cfg_load = 1'b0;
    send_word(8'hAA, 1'b1, 4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_total", 32'(total_hits), 32'd0);
    send_word(8'h0A, 1'b1, 4'd1);
    wait_done();
    check("mid_rst_total_after", 32'(total_hits), 32'd1);

    // Saturation of the running total.
    force dut.total_q = 16'hFFFE;
    @(negedge clk);
    release dut.total_q;
    @(negedge clk);
    check("sat_preload", 32'(total_hits), 32'hFFFE);
    send_word(8'hAA, 1'b1, 4'd3);
    wait_done();
    check("sat_total", 32'(total_hits), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
